pix_word_packer: RTL and testbench

- Sits directly downstream of the pixel-capture FIFO in the pix_clk domain; consumes its 12-bit pixel/valid stream.
- Packs 4 pixels (48 bits) into 3 little-endian 16-bit words for the RAM write path.
- Detects frame boundaries and tags the final word of each frame.
- Buffers words in a small output FIFO with ready/valid backpressure; the upstream side cannot stall, so drops are flagged.

---
 rtl/pix_word_packer.sv | 211 +++++++++++++++++++++
 tb/tb_pix_word_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_word_packer.sv
// Packs 12-bit pixels into little-endian 16-bit words (4 pixels -> 3 words), tags the final
// word of each frame and buffers words in a first-word fall-through FIFO with drop flagging.
module pix_word_packer #(
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned IdleCycles = 4,
  parameter int unsigned CountWidth = 24
) (
  input  logic                  pix_clk,
  input  logic                  pix_rst_n,
  input  logic                  pix_frameValid,
  input  logic [11:0]           pix_d,
  input  logic                  pix_dValid,
  output logic [15:0]           word_d,
  output logic                  word_last,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overflow,
  output logic [CountWidth-1:0] frame_pixCount,
  output logic                  frame_done
);

  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned IdleW = $clog2(IdleCycles + 1);
  localparam logic [IdleW-1:0]      IdleMax  = IdleW'(IdleCycles);
  localparam logic [IdleW-1:0]      IdleOne  = IdleW'(1);
  localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

  typedef enum logic [1:0] {StIdle, StActive, StFlushStage, StFlushResid} state_e;

  state_e                state_q, state_d;
  logic [1:0]            phase_q, phase_d, phase_cur;
  // Leftover pixel bits, right-aligned and zero-padded above.
  logic [11:0]           resid_q, resid_d;
  logic [15:0]           stage_q, stage_d, new_word;
  logic                  stage_vld_q, stage_vld_d, stage_vld_cur;
  logic [IdleW-1:0]      idle_q, idle_d, idle_inc;
  logic [CountWidth-1:0] count_q, count_d, count_cur;
  logic                  ovf_q, ovf_set, ovf_clr;
  logic                  done_q, done_d;
  logic                  accept, push, push_last;
  logic [15:0]           push_word;

  logic [16:0]           mem_q [FifoDepth];
  logic [PtrW:0]         wr_ptr_q, rd_ptr_q;
  logic                  full, empty, do_pop;
  logic [16:0]           head;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    resid_d       = resid_q;
    stage_d       = stage_q;
    stage_vld_d   = stage_vld_q;
    idle_d        = idle_q;
    count_d       = count_q;
    done_d        = 1'b0;
    ovf_set       = 1'b0;
    ovf_clr       = 1'b0;
    push          = 1'b0;
    push_word     = stage_q;
    push_last     = 1'b0;
    accept        = 1'b0;
    new_word      = '0;
    phase_cur     = phase_q;
    stage_vld_cur = stage_vld_q;
    count_cur     = count_q;
    idle_inc      = idle_q + IdleOne;

    unique case (state_q)
      StIdle: begin
        if (pix_frameValid) begin
          state_d       = StActive;
          accept        = pix_dValid;
          phase_cur     = '0;
          phase_d       = '0;
          stage_vld_cur = 1'b0;
          stage_vld_d   = 1'b0;
          count_cur     = '0;
          count_d       = '0;
          idle_d        = '0;
          ovf_clr       = 1'b1;
        end
      end
      StActive: begin
        accept = pix_dValid;
        if (!pix_frameValid && !pix_dValid) begin
          if (idle_inc == IdleMax) begin
            idle_d  = '0;
            state_d = StFlushStage;
          end else begin
            idle_d = idle_inc;
          end
        end else begin
          idle_d = '0;
        end
      end
      StFlushStage: begin
        ovf_set = pix_dValid;
        if (stage_vld_q) begin
          push        = 1'b1;
          push_word   = stage_q;
          push_last   = (phase_q == 2'd0);
          stage_vld_d = 1'b0;
        end
        if (phase_q != 2'd0) begin
          state_d = StFlushResid;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StFlushResid: begin
        ovf_set   = pix_dValid;
        push      = 1'b1;
        push_word = {4'b0, resid_q};
        push_last = 1'b1;
        phase_d   = '0;
        state_d   = StIdle;
        done_d    = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      count_d = (&count_cur) ? count_cur : count_cur + CountOne;
      phase_d = phase_cur + 2'd1;
      unique case (phase_cur)
        2'd0: resid_d = pix_d;
        2'd1: begin
          new_word = {pix_d[3:0], resid_q};
          resid_d  = {4'b0, pix_d[11:4]};
        end
        2'd2: begin
          new_word = {pix_d[7:0], resid_q[7:0]};
          resid_d  = {8'b0, pix_d[11:8]};
        end
        2'd3: begin
          new_word = {pix_d, resid_q[3:0]};
          resid_d  = '0;
        end
        default: resid_d = resid_q;
      endcase
      // A new word displaces the staged one into the FIFO; the staged word is never last here.
      if (phase_cur != 2'd0) begin
        stage_d     = new_word;
        stage_vld_d = 1'b1;
        if (stage_vld_cur) begin
          push      = 1'b1;
          push_word = stage_q;
          push_last = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      resid_q     <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      idle_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      resid_q     <= resid_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      idle_q      <= idle_d;
      count_q     <= count_d;
      done_q      <= done_d;
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (ovf_set || (push && full)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Fullness is taken before any same-cycle pop, so a push into a full FIFO always drops.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign do_pop = !empty && word_ready;

  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (push && !full) mem_q[wr_ptr_q[PtrW-1:0]] <= {push_last, push_word};
  end

  assign head           = mem_q[rd_ptr_q[PtrW-1:0]];
  assign word_valid     = !empty;
  assign word_d         = empty ? 16'h0 : head[15:0];
  assign word_last      = !empty && head[16];
  assign overflow       = ovf_q;
  assign frame_pixCount = count_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_pix_word_packer.sv
// Directed bench for pix_word_packer: a bit-stream packing model feeds an expected-word
// scoreboard checked on every FIFO pop, with literal word lists pinning the model.
module tb_pix_word_packer;
  localparam int Depth = 8;
  localparam int Idle  = 4;
  localparam int CW    = 24;

  typedef struct packed {
    logic [15:0] w;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_valid, d_valid, word_ready;
  logic [11:0]   pix_d;
  logic [15:0]   word_d;
  logic          word_last, word_valid, overflow, frame_done;
  logic [CW-1:0] pix_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [11:0] pix_q[$];
  logic [15:0] lit_q[$];
  exp_t        model_q[$];
  exp_t        exp_q[$];

  pix_word_packer #(
    .FifoDepth (Depth),
    .IdleCycles(Idle),
    .CountWidth(CW)
  ) dut (
    .pix_clk       (clk),
    .pix_rst_n     (rst_n),
    .pix_frameValid(frame_valid),
    .pix_d         (pix_d),
    .pix_dValid    (d_valid),
    .word_d        (word_d),
    .word_last     (word_last),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .overflow      (overflow),
    .frame_pixCount(pix_count),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixels form one LSB-first bit stream cut into 16-bit words; the tail is zero-padded.
  task automatic build_model();
    bit bq[$];
    logic [15:0] w;
    model_q.delete();
    foreach (pix_q[i]) begin
      for (int b = 0; b < 12; b++) begin
        bq.push_back(pix_q[i][b]);
        if (bq.size() == 16) begin
          for (int k = 0; k < 16; k++) w[k] = bq.pop_front();
          model_q.push_back('{w: w, l: 1'b0});
        end
      end
    end
    if (bq.size() > 0) begin
      w = '0;
      for (int k = 0; bq.size() > 0; k++) w[k] = bq.pop_front();
      model_q.push_back('{w: w, l: 1'b0});
    end
    if (model_q.size() > 0) model_q[model_q.size()-1].l = 1'b1;
  endtask

  task automatic pin_model();
    chk("model_len", model_q.size(), lit_q.size());
    foreach (lit_q[i]) if (i < model_q.size()) chk("model_word", model_q[i].w, lit_q[i]);
  endtask

  task automatic load_expect(input int keep, input bit keep_last);
    foreach (model_q[i]) begin
      if (i < keep) exp_q.push_back('{w: model_q[i].w, l: keep_last ? model_q[i].l : 1'b0});
    end
  endtask

  task automatic run_frame(input int gap_at, input int gap_len);
    done_cnt = 0;
    foreach (pix_q[i]) begin
      if (i == gap_at) begin
        frame_valid = 1'b0;
        d_valid     = 1'b0;
        repeat (gap_len) tick();
      end
      frame_valid = 1'b1;
      d_valid     = 1'b1;
      pix_d       = pix_q[i];
      tick();
    end
    frame_valid = 1'b0;
    d_valid     = 1'b0;
    pix_d       = '0;
    for (int t = 0; t < 60 && done_cnt == 0; t++) tick();
    repeat (Depth + 4) tick();
    chk("frame_done_count", done_cnt, 1);
  endtask

  // Scoreboard: every accepted word must match the next expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h last=%0b, none expected", word_d, word_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_d", word_d, e.w);
          chk("word_last", word_last, e.l);
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; frame_valid = 1'b0; d_valid = 1'b0; pix_d = '0; word_ready = 1'b1;
    repeat (3) tick();
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_d", word_d, 0);
    chk("rst_word_last", word_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", pix_count, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    tick();

    // Basic packing, one full group per 4 pixels.
    pix_q = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'hFED, 12'hCBA, 12'h987, 12'h654};
    lit_q = '{16'h3ABC, 16'h5612, 16'h7894, 16'hAFED, 16'h87CB, 16'h6549};
    build_model();
    pin_model();
    chk("model_last_basic", model_q[5].l, 1);
    load_expect(99, 1'b1);
    run_frame(-1, 0);
    chk("basic_drained", exp_q.size(), 0);
    chk("basic_count", pix_count, 8);
    chk("basic_overflow", overflow, 0);

    // Residual flush.
    pix_q = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    lit_q = '{16'h2001, 16'h0300, 16'h0040, 16'h0005};
    build_model();
    pin_model();
    load_expect(99, 1'b1);
    run_frame(-1, 0);
    chk("resid_drained", exp_q.size(), 0);
    chk("resid_count", pix_count, 5);

    // Backpressure: only the first Depth words survive, the tagged final word is dropped.
    word_ready = 1'b0;
    pix_q.delete();
    for (int i = 0; i < 24; i++) pix_q.push_back(12'(i * 173 + 17));
    build_model();
    chk("model_len_bp", model_q.size(), 18);
    load_expect(Depth, 1'b0);
    run_frame(-1, 0);
    chk("bp_valid_held", word_valid, 1);
    chk("bp_overflow", overflow, 1);
    chk("bp_count", pix_count, 24);
    word_ready = 1'b1;
    repeat (Depth + 4) tick();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_empty", word_valid, 0);

    // Empty frame; its start also clears the sticky overflow.
    done_cnt = 0;
    frame_valid = 1'b1;
    tick();
    chk("ovf_cleared", overflow, 0);
    repeat (9) tick();
    frame_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("empty_done_timing", frame_done, (k == Idle + 1) ? 1 : 0);
    end
    chk("empty_done_count", done_cnt, 1);
    chk("empty_no_words", word_valid, 0);
    chk("empty_count", pix_count, 0);

    // Short idle gap keeps the frame open.
    pix_q.delete();
    for (int i = 0; i < 12; i++) pix_q.push_back(12'(i * 291 + 100));
    build_model();
    chk("model_len_gap", model_q.size(), 9);
    load_expect(99, 1'b1);
    run_frame(8, Idle - 1);
    chk("gap_drained", exp_q.size(), 0);
    chk("gap_count", pix_count, 12);

    // Reset mid-frame discards everything at once.
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      frame_valid = 1'b1;
      d_valid     = 1'b1;
      pix_d       = 12'(i + 3);
      tick();
    end
    chk("mid_valid_before", word_valid, 1);
    chk("mid_count_before", pix_count, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_count", pix_count, 0);
    frame_valid = 1'b0;
    d_valid     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    word_ready = 1'b1;
    pix_q = '{12'h111, 12'h222, 12'h333, 12'h444};
    lit_q = '{16'h2111, 16'h3322, 16'h4443};
    build_model();
    pin_model();
    load_expect(99, 1'b1);
    run_frame(-1, 0);
    chk("post_rst_drained", exp_q.size(), 0);
    chk("post_rst_count", pix_count, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
